// File: rtl/eth_tx_sched.sv
// ---------------------------------------------------------------------------
// eth_tx_sched
//
// Purpose:
//   Shares the single Ethernet transmit path (eth_tx_block) between three
//   frame sources: the ack/nack generator (ACK), the debug send-data queue
//   (SND) and the memory-response engine (MEM). Exactly one frame is offered
//   at a time on the tx block's queue-style interface. The tx block's payload
//   BRAM address is rebased onto the granted source's buffer window, and an
//   inter-frame gap of IFG_CYCLES idle cycles is enforced after tx_en falls.
//
// Parameters:
//   IFG_CYCLES     idle cycles after tx_en falls before the next offer (1..255)
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   ack_req/val    ack/nack frame pending, 1=ack 0=nack
//   ack_pop        one-cycle accept pulse back to the ack source
//   snd_req/len/base, snd_pop   send-data descriptor and accept pulse
//   mem_req/len/base, mem_pop   memory-response descriptor and accept pulse
//   tx_ack_empty, tx_ack_data, tx_send_empty, tx_len, tx_mem_ack
//                  registered offer towards eth_tx_block
//   tx_ack_re, tx_send_re, tx_en, tx_addr
//                  read strobes, frame-in-progress and payload address from
//                  eth_tx_block
//   bram_addr      tx_addr rebased onto the granted buffer (combinational)
//   frame_cnt      frames accepted since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module eth_tx_sched #(
    parameter int IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ack_req,
    input  logic        ack_val,
    output logic        ack_pop,
    input  logic        snd_req,
    input  logic [15:0] snd_len,
    input  logic [9:0]  snd_base,
    output logic        snd_pop,
    input  logic        mem_req,
    input  logic [15:0] mem_len,
    input  logic [9:0]  mem_base,
    output logic        mem_pop,
    output logic        tx_ack_empty,
    output logic        tx_ack_data,
    output logic        tx_send_empty,
    output logic [15:0] tx_len,
    output logic        tx_mem_ack,
    input  logic        tx_ack_re,
    input  logic        tx_send_re,
    input  logic        tx_en,
    input  logic [9:0]  tx_addr,
    output logic [9:0]  bram_addr,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_OFFER,
        SCH_BUSY,
        SCH_GAP
    } state_t;

    typedef enum logic [1:0] {
        SRC_ACK,
        SRC_SND,
        SRC_MEM
    } src_t;

    // The counter runs from IFG_CYCLES-1 down to 0, giving IFG_CYCLES gap cycles.
    localparam logic [7:0] GAP_LOAD = 8'(IFG_CYCLES - 1);

    state_t      state_q,      state_d;
    src_t        last_q,       last_d;
    src_t        cur_q,        cur_d;
    logic        ack_empty_q,  ack_empty_d;
    logic        ack_data_q,   ack_data_d;
    logic        send_empty_q, send_empty_d;
    logic [15:0] len_q,        len_d;
    logic        mem_ack_q,    mem_ack_d;
    logic [9:0]  base_q,       base_d;
    logic        ack_pop_q,    ack_pop_d;
    logic        snd_pop_q,    snd_pop_d;
    logic        mem_pop_q,    mem_pop_d;
    logic [15:0] cnt_q,        cnt_d;
    logic [7:0]  gap_q,        gap_d;

    src_t        win;
    logic        any_req;
    logic        strobe_hit;

    // Round-robin arbiter: search starts at the source after the last winner,
    // so a continuously requesting source waits at most two frames.
    always_comb begin
        win     = SRC_ACK;
        any_req = ack_req | snd_req | mem_req;
        case (last_q)
            SRC_ACK: begin
                if (snd_req)      win = SRC_SND;
                else if (mem_req) win = SRC_MEM;
                else              win = SRC_ACK;
            end
            SRC_SND: begin
                if (mem_req)      win = SRC_MEM;
                else if (ack_req) win = SRC_ACK;
                else              win = SRC_SND;
            end
            default: begin
                if (ack_req)      win = SRC_ACK;
                else if (snd_req) win = SRC_SND;
                else              win = SRC_MEM;
            end
        endcase
    end

    // The ack frame is consumed through tx_ack_re; send and memory frames both
    // use the send-data queue and are consumed through tx_send_re.
    always_comb begin
        strobe_hit = (cur_q == SRC_ACK) ? tx_ack_re : tx_send_re;
    end

    // Next-state and registered-output logic of the scheduler FSM.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cur_d        = cur_q;
        ack_empty_d  = ack_empty_q;
        ack_data_d   = ack_data_q;
        send_empty_d = send_empty_q;
        len_d        = len_q;
        mem_ack_d    = mem_ack_q;
        base_d       = base_q;
        ack_pop_d    = 1'b0;
        snd_pop_d    = 1'b0;
        mem_pop_d    = 1'b0;
        cnt_d        = cnt_q;
        gap_d        = gap_q;

        case (state_q)
            SCH_IDLE: begin
                if (any_req) begin
                    last_d  = win;
                    cur_d   = win;
                    state_d = SCH_OFFER;
                    case (win)
                        SRC_ACK: begin
                            ack_empty_d = 1'b0;
                            ack_data_d  = ack_val;
                            len_d       = 16'd0;
                            base_d      = 10'd0;
                            mem_ack_d   = 1'b0;
                        end
                        SRC_SND: begin
                            send_empty_d = 1'b0;
                            len_d        = snd_len;
                            base_d       = snd_base;
                            mem_ack_d    = 1'b0;
                        end
                        default: begin
                            send_empty_d = 1'b0;
                            len_d        = mem_len;
                            base_d       = mem_base;
                            mem_ack_d    = 1'b1;
                        end
                    endcase
                end
            end

            SCH_OFFER: begin
                if (strobe_hit) begin
                    ack_empty_d  = 1'b1;
                    send_empty_d = 1'b1;
                    cnt_d        = cnt_q + 16'd1;
                    state_d      = SCH_BUSY;
                    case (cur_q)
                        SRC_ACK: ack_pop_d = 1'b1;
                        SRC_SND: snd_pop_d = 1'b1;
                        default: mem_pop_d = 1'b1;
                    endcase
                end
            end

            // A frame that never raises tx_en (ack or zero length) leaves after one cycle.
            SCH_BUSY: begin
                if (!tx_en) begin
                    gap_d   = GAP_LOAD;
                    state_d = SCH_GAP;
                end
            end

            // Length and mem flag stay visible through the gap and are cleared on exit.
            SCH_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d   = SCH_IDLE;
                    mem_ack_d = 1'b0;
                    len_d     = 16'd0;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end

            default: begin
                state_d = SCH_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any offer without a pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SCH_IDLE;
            last_q       <= SRC_MEM;
            cur_q        <= SRC_ACK;
            ack_empty_q  <= 1'b1;
            ack_data_q   <= 1'b0;
            send_empty_q <= 1'b1;
            len_q        <= 16'd0;
            mem_ack_q    <= 1'b0;
            base_q       <= 10'd0;
            ack_pop_q    <= 1'b0;
            snd_pop_q    <= 1'b0;
            mem_pop_q    <= 1'b0;
            cnt_q        <= 16'd0;
            gap_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cur_q        <= cur_d;
            ack_empty_q  <= ack_empty_d;
            ack_data_q   <= ack_data_d;
            send_empty_q <= send_empty_d;
            len_q        <= len_d;
            mem_ack_q    <= mem_ack_d;
            base_q       <= base_d;
            ack_pop_q    <= ack_pop_d;
            snd_pop_q    <= snd_pop_d;
            mem_pop_q    <= mem_pop_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
        end
    end

    assign ack_pop       = ack_pop_q;
    assign snd_pop       = snd_pop_q;
    assign mem_pop       = mem_pop_q;
    assign tx_ack_empty  = ack_empty_q;
    assign tx_ack_data   = ack_data_q;
    assign tx_send_empty = send_empty_q;
    assign tx_len        = len_q;
    assign tx_mem_ack    = mem_ack_q;
    assign frame_cnt     = cnt_q;

    // Buffer windows wrap modulo the 1024-word BRAM.
    assign bram_addr = base_q + tx_addr;

endmodule
